// File: rtl/ah_demux_pkg.sv
// Shared types and constants for the packet-steering demultiplexer.
package ah_demux_pkg;

  typedef enum logic [0:0] {
    FSM_SOP = 1'b0,
    FSM_MID = 1'b1
  } fsm_state_e;

  localparam int DROP_CNT_W = 16;

  // Minimum select width able to address n egress ports.
  function automatic int min_sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ah_demux_egr_slot.sv
// One-entry egress register slice: a load overwrites the slot; an accepted
// beat with no new load empties it.
module ah_demux_egr_slot #(
  parameter int DATA_W = 258
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              last,
  input  logic              egr_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data_q,
  output logic              last_q,
  output logic              free
);

  assign free = !valid || egr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      data_q <= data;
      last_q <= last;
    end else if (valid && egr_ready) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/ah_demux_pipe.sv
// 1-to-N valid/ready demux with per-egress output registers and packet lock.
// Optional saturating drop counter: define AH_DEMUX_DROP_CNT_EN.
module ah_demux_pipe
  import ah_demux_pkg::*;
#(
  parameter int DATA_W = 258,
  parameter int N_EGR  = 11,
  parameter int SEL_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        select,
  input  logic [DATA_W-1:0]       ing_data,
  input  logic                    ing_valid,
  input  logic                    ing_last,
  output logic                    ing_ready,
  output logic [N_EGR*DATA_W-1:0] egr_data,
  output logic [N_EGR-1:0]        egr_valid,
  output logic [N_EGR-1:0]        egr_last,
  input  logic [N_EGR-1:0]        egr_ready,
  output logic                    drop_pulse,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam logic [0:0]       ST_SOP   = FSM_SOP;
  localparam logic [0:0]       ST_MID   = FSM_MID;
  localparam logic [SEL_W:0]   N_EGR_SW = (SEL_W+1)'(N_EGR);

  if (SEL_W < min_sel_w(N_EGR)) begin : g_bad_sel_w
    $error("SEL_W too narrow for N_EGR");
  end

  logic [0:0]       state;
  logic [SEL_W-1:0] locked_sel;
  logic [SEL_W-1:0] eff_sel;
  logic             in_range;
  logic             sel_free;
  logic             accept;
  logic [N_EGR-1:0] free;

  // Handshake: a beat moves when valid && ready on the same rising edge;
  // ready never depends on the valid of the same interface.
  assign eff_sel  = (state == ST_MID) ? locked_sel : select;
  assign in_range = ({1'b0, eff_sel} < N_EGR_SW);

  always_comb begin
    sel_free = 1'b0;
    for (int i = 0; i < N_EGR; i++) begin
      if (eff_sel == SEL_W'(i)) sel_free = free[i];
    end
  end

  assign ing_ready = in_range ? sel_free : 1'b1;
  assign accept    = ing_valid && ing_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SOP;
      locked_sel <= '0;
    end else if (accept) begin
      if (state == ST_SOP && !ing_last) begin
        state      <= ST_MID;
        locked_sel <= select;
      end else if (state == ST_MID && ing_last) begin
        state      <= ST_SOP;
      end
    end
  end

  for (genvar i = 0; i < N_EGR; i++) begin : g_slot
    logic load;
    assign load = accept && in_range && (eff_sel == SEL_W'(i));

    ah_demux_egr_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .data      (ing_data),
      .last      (ing_last),
      .egr_ready (egr_ready[i]),
      .valid     (egr_valid[i]),
      .data_q    (egr_data[i*DATA_W +: DATA_W]),
      .last_q    (egr_last[i]),
      .free      (free[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_pulse <= 1'b0;
    else        drop_pulse <= accept && !in_range;
  end

`ifdef AH_DEMUX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // Counts on the same edge that raises drop_pulse, so both change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (accept && !in_range && drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ah_demux_pipe.sv
// Scoreboard bench for ah_demux_pipe: per-egress expected queues filled on
// ingress acceptance and drained on egress handshakes.
module tb_ah_demux_pipe;
  localparam int DATA_W = 258;
  localparam int N_EGR  = 11;
  localparam int SEL_W  = 4;
  localparam int BUDGET = 200;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [SEL_W-1:0]        select = '0;
  logic [DATA_W-1:0]       ing_data = '0;
  logic                    ing_valid = 1'b0;
  logic                    ing_last = 1'b0;
  logic                    ing_ready;
  logic [N_EGR*DATA_W-1:0] egr_data;
  logic [N_EGR-1:0]        egr_valid;
  logic [N_EGR-1:0]        egr_last;
  logic [N_EGR-1:0]        egr_ready = '1;
  logic                    drop_pulse;
  logic [15:0]             drop_cnt;

  ah_demux_pipe #(.DATA_W(DATA_W), .N_EGR(N_EGR), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .select(select), .ing_data(ing_data),
    .ing_valid(ing_valid), .ing_last(ing_last), .ing_ready(ing_ready),
    .egr_data(egr_data), .egr_valid(egr_valid), .egr_last(egr_last),
    .egr_ready(egr_ready), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int exp_drops = 0;
  int seen_drops = 0;
  logic [15:0] exp_cnt = '0;
  logic m_mid = 1'b0;
  logic [SEL_W-1:0] m_sel = '0;
  logic [DATA_W:0] exp_q [N_EGR][$];
  logic rnd_on = 1'b0;

  task automatic chk(input string tag, input logic [263:0] act, input logic [263:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboard: sampled 2 time units after the falling edge
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      for (int i = 0; i < N_EGR; i++) begin
        if (egr_valid[i] && egr_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("egr%0d_unexpected", i), 264'(egr_valid[i]), 264'(0));
          end else begin
            chk($sformatf("egr%0d_beat", i),
                264'({egr_last[i], egr_data[i*DATA_W +: DATA_W]}),
                264'(exp_q[i].pop_front()));
          end
        end
      end
      if (drop_pulse) seen_drops++;
      if (ing_valid && ing_ready) begin
        logic [SEL_W-1:0] eff;
        eff = m_mid ? m_sel : select;
        if (int'(eff) < N_EGR) begin
          exp_q[eff].push_back({ing_last, ing_data});
        end else begin
          exp_drops++;
          if (exp_cnt != 16'hFFFF) exp_cnt++;
        end
        if (!m_mid && !ing_last) begin
          m_mid = 1'b1;
          m_sel = select;
        end else if (m_mid && ing_last) begin
          m_mid = 1'b0;
        end
        acc_cnt++;
      end
    end
  end

  // driver: starts and ends on a falling edge
  task automatic send_beat(input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] d, input logic l);
    int start;
    int k;
    start = acc_cnt;
    k = 0;
    select = s; ing_data = d; ing_last = l; ing_valid = 1'b1;
    #3;
    while (acc_cnt == start && k < BUDGET) begin
      @(negedge clk); #3;
      k++;
    end
    if (acc_cnt == start) chk("accept_timeout", 264'(k), 264'(0));
    @(negedge clk);
    ing_valid = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return DATA_W'({$urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom});
  endfunction

  function automatic logic [DATA_W-1:0] lane(input int i);
    return egr_data[i*DATA_W +: DATA_W];
  endfunction

  always @(negedge clk) begin
    if (rnd_on) egr_ready = N_EGR'($urandom);
  end

  logic [DATA_W-1:0] d0;
  longint t0;
  int base;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_egr_valid", 264'(egr_valid), 264'(0));
    chk("rst_egr_last", 264'(egr_last), 264'(0));
    chk("rst_egr_data_zero", 264'(|egr_data), 264'(0));
    chk("rst_drop_pulse", 264'(drop_pulse), 264'(0));
    chk("rst_drop_cnt", 264'(drop_cnt), 264'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // single-beat steering
    send_beat(4'd3, DATA_W'(8'hA5), 1'b1);
    #1;
    chk("single_valid", 264'(egr_valid), 264'(11'b000_0000_1000));
    chk("single_lane3", 264'(lane(3)), 264'(8'hA5));
    chk("single_ready", 264'(ing_ready), 264'(1));
    @(negedge clk);

    // packet lock: select changes mid-packet are ignored
    send_beat(4'd2, rnd_data(), 1'b0);
    send_beat(4'd7, rnd_data(), 1'b0);
    send_beat(4'd7, rnd_data(), 1'b1);
    send_beat(4'd7, rnd_data(), 1'b1);
    repeat (2) @(negedge clk);

    // backpressure on egress 5
    egr_ready = ~(N_EGR'(1) << 5);
    d0 = rnd_data();
    send_beat(4'd5, d0, 1'b1);
    select = 4'd5;
    #1;
    chk("bp_ing_ready_low", 264'(ing_ready), 264'(0));
    chk("bp_valid5", 264'(egr_valid[5]), 264'(1));
    repeat (3) @(negedge clk);
    #1;
    chk("bp_lane5_held", 264'(lane(5)), 264'(d0));
    chk("bp_valid5_held", 264'(egr_valid[5]), 264'(1));
    @(negedge clk);
    egr_ready = '1;
    t0 = $time;
    for (int b = 0; b < 4; b++) send_beat(4'd5, rnd_data(), b == 3);
    chk("bp_throughput_cycles", 264'(($time - t0) / 10), 264'(4));
    repeat (2) @(negedge clk);

    // out-of-range select: whole packet dropped
    base = seen_drops;
    t0 = $time;
    for (int b = 0; b < 4; b++) send_beat(4'd12, rnd_data(), b == 3);
    chk("drop_no_stall_cycles", 264'(($time - t0) / 10), 264'(4));
    repeat (2) @(negedge clk);
    #1;
    chk("drop_pulse_count", 264'(seen_drops - base), 264'(4));
    chk("drop_egr_idle", 264'(egr_valid), 264'(0));
`ifdef AH_DEMUX_DROP_CNT_EN
    chk("drop_cnt_4", 264'(drop_cnt), 264'(4));
`else
    chk("drop_cnt_tied", 264'(drop_cnt), 264'(0));
`endif
    @(negedge clk);

    // asynchronous reset while mid-packet with a stuck egress beat
    egr_ready = ~(N_EGR'(1) << 1);
    send_beat(4'd1, rnd_data(), 1'b0);
    #1;
    chk("pre_rst_valid1", 264'(egr_valid[1]), 264'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 264'(egr_valid), 264'(0));
    for (int i = 0; i < N_EGR; i++) exp_q[i].delete();
    m_mid = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    egr_ready = '1;
    d0 = rnd_data();
    send_beat(4'd4, d0, 1'b1);
    #1;
    chk("post_rst_valid4", 264'(egr_valid), 264'(11'b000_0001_0000));
    chk("post_rst_lane4", 264'(lane(4)), 264'(d0));
    @(negedge clk);

    // random packets under random egress backpressure
    rnd_on = 1'b1;
    for (int p = 0; p < 30; p++) begin
      int len;
      logic [SEL_W-1:0] s;
      len = $urandom_range(1, 4);
      s = SEL_W'($urandom_range(0, 13));
      for (int b = 0; b < len; b++) send_beat(s, rnd_data(), b == len - 1);
    end
    rnd_on = 1'b0;
    @(negedge clk);
    egr_ready = '1;
    repeat (5) @(negedge clk);

`ifdef AH_DEMUX_DROP_CNT_EN
    chk("cnt_model", 264'(drop_cnt), 264'(exp_cnt));
    force dut.drop_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.drop_cnt_q;
    for (int b = 0; b < 3; b++) send_beat(4'd15, rnd_data(), 1'b1);
    repeat (2) @(negedge clk);
    chk("cnt_saturate", 264'(drop_cnt), 264'(16'hFFFF));
`endif

    #1;
    chk("drops_total", 264'(seen_drops), 264'(exp_drops));
    for (int i = 0; i < N_EGR; i++) begin
      chk($sformatf("egr%0d_drained", i), 264'(exp_q[i].size()), 264'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ah_demux_pipe.md
Name: ah_demux_pipe

Overview:
Parametrised 1-to-N valid/ready demultiplexer with a registered egress stage. It is the successor to the combinational fixed-width demux.
- Adds packet-level steering: select is sampled on the first beat and held until the beat carrying ing_last.
- Adds per-egress output registers, so there is no combinational data/valid path from ingress to egress.
- Discards traffic whose select is out of range and flags the drop.
- Sits between a packet source and N downstream consumers in the datapath fabric.

Parameters:
DATA_W, 258, width of ing_data and of each egress data lane
N_EGR, 11, number of egress ports (2..16)
SEL_W, 4, width of select; must satisfy 2**SEL_W >= N_EGR

Ports:
clk  input  1  single clock
rst_n  input  1  asynchronous active-low reset
select  input  SEL_W  egress index; sampled only at packet start
ing_data  input  DATA_W  ingress beat data
ing_valid  input  1  ingress beat valid
ing_last  input  1  ingress final beat of packet
ing_ready  output  1  ingress beat accepted when ing_valid && ing_ready
egr_data  output  N_EGR*DATA_W  egress i occupies bits [i*DATA_W +: DATA_W]
egr_valid  output  N_EGR  per-egress valid
egr_last  output  N_EGR  per-egress last
egr_ready  input  N_EGR  per-egress ready
drop_pulse  output  1  one-cycle pulse per discarded beat
drop_cnt  output  16  discarded-beat count (see Optional Feature)

Behaviour:
- Reset (async assert, sync-released use): egr_valid=0, egr_last=0, egr_data=0, drop_pulse=0, drop_cnt=0, FSM=SOP, locked_sel=0.
- FSM states:
  - SOP: eff_sel = select.
  - MID: eff_sel = locked_sel; the select input is ignored.
- FSM transitions:
  - SOP -> MID on an accepted beat with ing_last=0; locked_sel <= select.
  - MID -> SOP on an accepted beat with ing_last=1.
  - A single-beat packet (last=1 in SOP) stays in SOP.
- Egress slot i is free when !egr_valid[i] || egr_ready[i], giving full throughput of one beat per cycle per egress.
- ing_ready:
  - When eff_sel < N_EGR: ing_ready = free[eff_sel], combinational from egr_ready and state.
  - When eff_sel >= N_EGR: ing_ready = 1.
- Accepted beat with eff_sel < N_EGR:
  - Next cycle egr_valid[eff_sel]=1, and egr_data/egr_last for that port are loaded.
  - Latency is exactly 1 cycle.
- Egress slot update:
  - Slot clears (egr_valid[i] <= 0) on egr_valid[i] && egr_ready[i] with no new load.
  - Simultaneous drain and load keeps valid=1 with the new data.
  - egr_data holds its value when not loaded; it is not zeroed.
- Out-of-range select (eff_sel >= N_EGR):
  - The beat is accepted and discarded.
  - drop_pulse=1 in the following cycle.
  - A packet started with an invalid select is dropped in its entirety, since locking applies.
- Other egress slots drain independently while ingress is stalled on a busy target.
- ing_valid=0 causes no state change; the FSM only advances on accepted beats.
- Reset mid-packet: the FSM returns to SOP and in-flight egress beats are lost. The upstream must restart the packet.
- No protocol checking on egress: a beat presented with egr_valid must be held until ready, per the slot logic above.

Optional Feature:
Macro AH_DEMUX_DROP_CNT_EN.
- Defined: drop_cnt increments by 1 in the cycle drop_pulse is asserted, saturates at 16'hFFFF, and clears only on reset.
- Undefined: the drop_cnt port remains and is tied to 16'd0; no counter flops exist. drop_pulse is present in both builds.

Decomposition:
- Package ah_demux_pkg:
  - FSM state enum (SOP, MID).
  - DROP_CNT_W = 16 constant.
  - Helper function for the minimum select width (clog2).
- Sub-module ah_demux_egr_slot: a one-entry register slice (load, data, last, egr_ready -> valid, data, last, free). It is instantiated N_EGR times via generate.

Test Plan:
- Single-beat steering: N_EGR=11, all egr_ready=1, select=3, send ing_data=0xA5 with last=1 -> next cycle egr_valid=11'b000_0000_1000 and egr_data lane 3 = 0xA5; ing_ready stays 1.
- Packet lock: in cycle 0 send select=2 with last=0. Change select to 7 for beats 1-2, with last=1 on beat 2 -> all 3 beats appear on egress 2 and none on egress 7. The following packet with select=7 goes to egress 7.
- Backpressure: select=5 with egr_ready[5]=0.
  - After one beat is loaded, ing_ready=0 and egr_valid[5] holds with unchanged data.
  - Raising egr_ready[5] drains it, and back-to-back beats then flow at 1 per cycle.
- Invalid select: select=12 with a 4-beat packet -> ing_ready=1 every beat, no egr_valid asserted, drop_pulse high 4 cycles. With AH_DEMUX_DROP_CNT_EN, drop_cnt=4; without it, drop_cnt=0.
- Async reset mid-packet: assert rst_n=0 between clock edges while in MID with egr_valid[1]=1 -> egr_valid=0 immediately. After release, a new packet steers by the fresh select value.
- Saturation (macro defined): force drop_cnt to 16'hFFFE, then drop 3 beats -> drop_cnt ends at 16'hFFFF.
